// File: rtl/inst_fmt_pkg.sv
// Instruction word format and loader state encoding, shared by the loader and the decode side.
package inst_fmt_pkg;

  localparam int unsigned INST_W   = 16;

  localparam int unsigned COND_W   = 2;
  localparam int unsigned OPCD_W   = 4;
  localparam int unsigned DEST_W   = 3;
  localparam int unsigned SRC_W    = 3;
  localparam int unsigned SRC2_W   = 4;

  localparam int unsigned COND_LSB = 14;
  localparam int unsigned OPCD_LSB = 10;
  localparam int unsigned DEST_LSB = 7;
  localparam int unsigned SRC_LSB  = 4;
  localparam int unsigned SRC2_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ld_state_t;

  typedef struct packed {
    logic [COND_W-1:0] cond;
    logic [OPCD_W-1:0] opcd;
    logic [DEST_W-1:0] dest;
    logic [SRC_W-1:0]  source;
    logic [SRC2_W-1:0] source2;
  } inst_fields_t;

endpackage

// File: rtl/inst_pack.sv
// Combinational packer: places each instruction field at its LSB position in the word.
module inst_pack
  import inst_fmt_pkg::*;
(
  input  inst_fields_t      fields,
  output logic [INST_W-1:0] word_c
);

  always_comb begin
    word_c = '0;
    word_c[COND_LSB +: COND_W] = fields.cond;
    word_c[OPCD_LSB +: OPCD_W] = fields.opcd;
    word_c[DEST_LSB +: DEST_W] = fields.dest;
    word_c[SRC_LSB  +: SRC_W]  = fields.source;
    word_c[SRC2_LSB +: SRC2_W] = fields.source2;
  end

endmodule

// File: rtl/inst_loader.sv
// Streams instruction field sets into program memory, one registered write per accepted beat.
// Optional feature: define LOAD_CHECKSUM_EN to add a running XOR checksum output.
module inst_loader
  import inst_fmt_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [COND_W-1:0] cond,
  input  logic [OPCD_W-1:0] opcd,
  input  logic [DEST_W-1:0] dest,
  input  logic [SRC_W-1:0]  source,
  input  logic [SRC2_W-1:0] source2,
  output logic              wr_en,
  output logic [AW-1:0]     wr_addr,
  output logic [INST_W-1:0] wr_data,
  output logic [AW:0]       count,
  output logic              busy,
  output logic              done
`ifdef LOAD_CHECKSUM_EN
  ,
  output logic [INST_W-1:0] checksum
`endif
);

  ld_state_t         state, state_nxt;
  logic              accept_c;
  logic              last_c;
  logic              session_start_c;
  logic [AW-1:0]     addr;
  inst_fields_t      fields;
  logic [INST_W-1:0] word_c;

  assign fields = '{cond: cond, opcd: opcd, dest: dest, source: source, source2: source2};

  inst_pack u_pack (
    .fields (fields),
    .word_c (word_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Session terminates on the in_last beat or on the beat that fills the last address.
  always_comb begin
    state_nxt       = state;
    accept_c        = 1'b0;
    last_c          = 1'b0;
    session_start_c = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt       = LOAD;
          session_start_c = 1'b1;
        end
      end
      LOAD: begin
        accept_c = in_valid & in_ready;
        last_c   = in_last | (addr == AW'(DEPTH - 1));
        if (accept_c && last_c) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          state_nxt       = LOAD;
          session_start_c = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      count    <= '0;
      addr     <= '0;
    end else begin
      in_ready <= (state_nxt == LOAD);
      busy     <= (state_nxt == LOAD);
      done     <= (state_nxt == DONE);
      wr_en    <= accept_c;
      if (session_start_c) begin
        addr  <= '0;
        count <= '0;
      end else if (accept_c) begin
        wr_addr <= addr;
        wr_data <= word_c;
        // Address holds at the top entry; only a new session brings it back to 0.
        if (addr != AW'(DEPTH - 1)) addr <= addr + AW'(1);
        if (count != (AW + 1)'(DEPTH)) count <= count + (AW + 1)'(1);
      end
    end
  end

`ifdef LOAD_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   checksum <= '0;
    else if (session_start_c)  checksum <= '0;
    else if (accept_c)         checksum <= checksum ^ word_c;
  end
`endif

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 SHALL have parameter: DEPTH, 64, number of program-memory words (power of two, >=2).
REQ-002 SHALL have parameter: AW, 6, write-address width, equal to log2(DEPTH).
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: start  input  1  one-cycle pulse that begins a load session.
REQ-006 SHALL have port: in_valid  input  1  field set present this cycle.
REQ-007 SHALL have port: in_ready  output  1  loader accepts a field set this cycle.
REQ-008 SHALL have port: in_last  input  1  accepted field set is the final instruction of the program.
REQ-009 SHALL have ports: cond  input  2, opcd  input  4, dest  input  3, source  input  3, source2  input  4; these are the instruction fields.
REQ-010 SHALL have port: wr_en  output  1  program-memory write strobe.
REQ-011 SHALL have port: wr_addr  output  AW  program-memory write address.
REQ-012 SHALL have port: wr_data  output  16  packed instruction word.
REQ-013 SHALL have port: count  output  AW+1  number of words written in the current session.
REQ-014 SHALL have ports: busy  output  1 (state LOAD), done  output  1 (state DONE).

Function
REQ-015 SHALL pack fields as follows: wr_data[15:14]=cond, [13:10]=opcd, [9:7]=dest, [6:4]=source, [3:0]=source2.
REQ-016 SHALL implement states IDLE, LOAD and DONE.
REQ-017 SHALL implement these transitions: IDLE -start-> LOAD; DONE -start-> LOAD; LOAD -> DONE on the accept of the in_last beat or on the accept of beat number DEPTH.
REQ-018 SHALL, on entering LOAD, set count to 0 and the internal address to 0.
REQ-019 SHALL ignore start while in LOAD.
REQ-020 SHALL drive in_ready=1 only in LOAD; an accept is in_valid&&in_ready.
REQ-021 SHALL, on an accept in cycle N, assert wr_en for exactly cycle N+1 with wr_addr equal to the pre-increment address and wr_data equal to the packed fields sampled in cycle N.
REQ-022 SHALL increment count in cycle N+1 for each accept; writes SHALL be back-to-back capable, at one per cycle.
REQ-023 SHALL drop in_ready in the cycle after the terminating accept, and the final write SHALL still occur.
REQ-024 SHALL NOT write or count in_valid while in IDLE or DONE.
REQ-025 SHALL wrap the address counter to 0 only on a new session; count SHALL saturate at DEPTH.
REQ-026 SHALL hold wr_addr and wr_data at their last values when wr_en=0.

Reset
REQ-027 SHALL, while rst=1, immediately force state=IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, count=0, busy=0, done=0 (and checksum=0).
REQ-028 SHALL, on reset asserted mid-session, suppress any pending write; no wr_en SHALL follow reset release without a new start.

Configuration
REQ-029 SHALL, when macro LOAD_CHECKSUM_EN is defined, add port checksum  output  16, the running XOR of all words written in the session; it SHALL be cleared on session start and updated in the same cycle as wr_en.
REQ-030 SHALL, when LOAD_CHECKSUM_EN is undefined, have no checksum port or logic, with all other behaviour identical.

Structure
REQ-031 SHALL take field LSB positions, field widths, instruction width (16) and the state enum from shared package inst_fmt_pkg, which is also used by the decode side.
REQ-032 SHALL place the packing in a combinational sub-module inst_pack (fields in, 16-bit word out); sequencing stays in inst_loader.

Verification
REQ-033 SHALL cover packing: start, then one beat cond=01, opcd=1010, dest=011, source=101, source2=0110, in_last=1 -> next cycle wr_en=1, wr_addr=0, wr_data=0x69D6; then done=1 and count=1.
REQ-034 SHALL cover burst: 5 consecutive accepts with in_last on the 5th -> wr_en high for 5 consecutive cycles, addresses 0..4, count=5, done=1.
REQ-035 SHALL cover full: DEPTH=4 and 6 beats offered with no in_last -> exactly 4 writes to addresses 0..3, in_ready=0 after the 4th accept, done=1, count=4.
REQ-036 SHALL cover idle and ignored start: in_valid=1 in IDLE for 10 cycles -> no wr_en; start pulsed mid-LOAD -> count and address unchanged.
REQ-037 SHALL cover reset: rst asserted in the same cycle as an accept -> no wr_en afterwards, all outputs 0; a subsequent start writes address 0.
REQ-038 SHALL cover checksum (LOAD_CHECKSUM_EN): write 0x69D6 then 0x1234 -> checksum=0x7BE2; a new start -> checksum=0.
